// File: rtl/scan_code_decoder.sv
// PS/2 set-2 scan-code consumer: prefix tracking, Shift/Caps state, ASCII translation
// and a small FIFO drained over a valid/ready handshake.
module scan_code_decoder #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [7:0]               scan_code,
   input  logic                     scan_code_ready,
   output logic [7:0]               ascii,
   output logic                     ascii_valid,
   input  logic                     ascii_ready,
   output logic                     shift_active,
   output logic                     caps_lock,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   fill
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_LEVEL = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

   state_t          state;
   logic            rdy_q;
   logic            shift_l;
   logic            shift_r;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [7:0]      mem [DEPTH];

   logic            accept;
   logic            code_hit;
   logic            code_letter;
   logic [7:0]      code_char;
   logic [7:0]      char_out;
   logic            push_req;
   logic            push;
   logic            pop;
   logic            full;

   always_comb begin
      code_hit    = 1'b1;
      code_letter = 1'b1;
      code_char   = '0;
      unique case (scan_code)
         8'h1C: code_char = 8'h61;
         8'h32: code_char = 8'h62;
         8'h21: code_char = 8'h63;
         8'h23: code_char = 8'h64;
         8'h24: code_char = 8'h65;
         8'h2B: code_char = 8'h66;
         8'h34: code_char = 8'h67;
         8'h33: code_char = 8'h68;
         8'h43: code_char = 8'h69;
         8'h3B: code_char = 8'h6A;
         8'h42: code_char = 8'h6B;
         8'h4B: code_char = 8'h6C;
         8'h3A: code_char = 8'h6D;
         8'h31: code_char = 8'h6E;
         8'h44: code_char = 8'h6F;
         8'h4D: code_char = 8'h70;
         8'h15: code_char = 8'h71;
         8'h2D: code_char = 8'h72;
         8'h1B: code_char = 8'h73;
         8'h2C: code_char = 8'h74;
         8'h3C: code_char = 8'h75;
         8'h2A: code_char = 8'h76;
         8'h1D: code_char = 8'h77;
         8'h22: code_char = 8'h78;
         8'h35: code_char = 8'h79;
         8'h1A: code_char = 8'h7A;
         default: begin
            code_letter = 1'b0;
            unique case (scan_code)
               8'h45: code_char = 8'h30;
               8'h16: code_char = 8'h31;
               8'h1E: code_char = 8'h32;
               8'h26: code_char = 8'h33;
               8'h25: code_char = 8'h34;
               8'h2E: code_char = 8'h35;
               8'h36: code_char = 8'h36;
               8'h3D: code_char = 8'h37;
               8'h3E: code_char = 8'h38;
               8'h46: code_char = 8'h39;
               8'h29: code_char = 8'h20;
               8'h5A: code_char = 8'h0D;
               8'h66: code_char = 8'h08;
               default: code_hit = 1'b0;
            endcase
         end
      endcase
   end

   // Shift/Caps are registers, so the case conversion sees the pre-byte state.
   assign char_out     = (code_letter && (shift_active ^ caps_lock)) ? code_char - 8'h20 : code_char;
   assign accept       = scan_code_ready && !rdy_q;
   assign push_req     = accept && (state == S_IDLE) && (scan_code != 8'hE0) &&
                         (scan_code != 8'hF0) && code_hit;
   assign full         = (fill == FULL_LEVEL);
   assign ascii_valid  = (fill != '0);
   assign pop          = ascii_valid && ascii_ready;
   assign push         = push_req && (!full || pop);
   assign ascii        = ascii_valid ? mem[rd_ptr] : '0;
   assign shift_active = shift_l | shift_r;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= S_IDLE;
         rdy_q     <= 1'b1;
         shift_l   <= 1'b0;
         shift_r   <= 1'b0;
         caps_lock <= 1'b0;
         overflow  <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fill      <= '0;
      end else begin
         rdy_q <= scan_code_ready;
         if (accept) begin
            unique case (state)
               S_IDLE: begin
                  if (scan_code == 8'hE0) begin
                     state <= S_EXT;
                  end else if (scan_code == 8'hF0) begin
                     state <= S_BRK;
                  end else if (scan_code == 8'h12) begin
                     shift_l <= 1'b1;
                  end else if (scan_code == 8'h59) begin
                     shift_r <= 1'b1;
                  end else if (scan_code == 8'h58) begin
                     caps_lock <= ~caps_lock;
                  end
               end
               S_BRK: begin
                  if (scan_code == 8'h12) shift_l <= 1'b0;
                  if (scan_code == 8'h59) shift_r <= 1'b0;
                  state <= S_IDLE;
               end
               S_EXT:     state <= (scan_code == 8'hF0) ? S_EXT_BRK : S_IDLE;
               S_EXT_BRK: state <= S_IDLE;
               default:   state <= S_IDLE;
            endcase
         end
         if (push_req && full && !pop) overflow <= 1'b1;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: fill <= fill;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= char_out;
   end

endmodule
